clk_div_sched: RTL

- Runtime-programmable clock-enable and divided-clock scheduler for the SDRAM clocking path.
- Produces a divided square wave and a one-cycle enable strobe from the system clock.
- Accepts new divide ratios over a valid/ready handshake and applies each change only at a period boundary, so no truncated or runt period is ever emitted.
- Reports lock status so downstream SDRAM timing logic knows when the divided clock is stable.

---
 rtl/clk_div_sched.sv | 127 ++++++++++++
 1 files changed

// File: rtl/clk_div_sched.sv
// Programmable clock divider / enable scheduler for the SDRAM clock path.
// Divisor changes are accepted over valid/ready and applied only at a period boundary.
module clk_div_sched #(
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned DIV_INIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cfg_valid,
  input  logic [DIV_W-1:0] i_cfg_div,
  output logic             o_cfg_ready,
  output logic             o_cfg_err,
  output logic             o_clk_div,
  output logic             o_clk_en,
  output logic             o_locked,
  output logic [DIV_W-1:0] o_cur_div
);

  localparam logic [DIV_W-1:0] DivInit = DIV_W'(DIV_INIT);
  localparam logic [DIV_W-1:0] DivOne  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DivTwo  = DIV_W'(2);

  typedef enum logic [1:0] {
    StSettle = 2'd0,
    StRun    = 2'd1,
    StPend   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             clk_div_q, clk_en_q, err_q;

  logic             boundary;
  logic             hand_shake;
  logic             div_ok;
  logic             cfg_ready;
  logic             locked;

  // Full-width compares: cnt never exceeds div_q-1, so no overflow even at 2^DIV_W-1.
  assign boundary   = (cnt_q == (div_q - DivOne));
  assign hand_shake = i_cfg_valid & cfg_ready;
  assign div_ok     = (i_cfg_div >= DivTwo);

  // State register and registered datapath.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StSettle;
      cnt_q     <= '0;
      div_q     <= DivInit;
      pend_q    <= '0;
      clk_div_q <= 1'b0;
      clk_en_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      pend_q    <= pend_d;
      // Waveform uses the divisor of the current cnt, so a period is never split.
      clk_div_q <= (cnt_q < (div_q >> 1));
      clk_en_q  <= boundary;
      err_q     <= hand_shake & ~div_ok;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    div_d   = div_q;
    cnt_d   = boundary ? '0 : cnt_q + DivOne;
    unique case (state_q)
      StSettle: begin
        if (boundary) state_d = StRun;
      end
      StRun: begin
        if (hand_shake && div_ok) begin
          pend_d  = i_cfg_div;
          state_d = StPend;
        end
      end
      StPend: begin
        if (boundary) begin
          div_d   = pend_q;
          state_d = StSettle;
        end
      end
      default: begin
        state_d = StSettle;
      end
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    cfg_ready = 1'b0;
    locked    = 1'b0;
    unique case (state_q)
      StSettle: begin
        cfg_ready = 1'b0;
        locked    = 1'b0;
      end
      StRun: begin
        cfg_ready = 1'b1;
        locked    = 1'b1;
      end
      StPend: begin
        cfg_ready = 1'b0;
        locked    = 1'b1;
      end
      default: begin
        cfg_ready = 1'b0;
        locked    = 1'b0;
      end
    endcase
  end

  assign o_cfg_ready = cfg_ready;
  assign o_locked    = locked;
  assign o_cfg_err   = err_q;
  assign o_clk_div   = clk_div_q;
  assign o_clk_en    = clk_en_q;
  assign o_cur_div   = div_q;

endmodule
